// File: rtl/ascon_aead128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_aead128_pkg
// Description : Shared constants, types and helpers for the Ascon-AEAD128
//               datapath: stream selectors, rate geometry, padder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_aead128_pkg;

    localparam logic SEL_AD = 1'b0;
    localparam logic SEL_DB = 1'b1;

    localparam int         RATE_BYTES = 16;
    localparam logic [7:0] PAD_BYTE   = 8'h01;

    typedef enum logic [1:0] {
        PAD_COLLECT  = 2'd0,
        PAD_EMIT     = 2'd1,
        PAD_EMIT_PAD = 2'd2
    } pad_state_e;

    // All-ones in every byte lane below n, zero elsewhere.
    function automatic logic [127:0] lane_mask(input logic [4:0] n);
        logic [127:0] mask;
        mask = '0;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (i < int'(n)) begin
                mask[8*i +: 8] = 8'hFF;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_input_padder.sv
`default_nettype none
// ============================================================================
// Module      : ascon_input_padder
// Description : Packs a 32-bit little-endian byte stream into 128-bit Ascon
//               rate blocks and applies 10* padding on the final block.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_input_padder
    import ascon_aead128_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  s_data,
    input  logic [2:0]   s_bytes,
    input  logic         s_type,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [127:0] m_block,
    output logic [4:0]   m_bytes,
    output logic         m_type,
    output logic         m_last,
    output logic         m_empty,
    output logic         m_valid,
    input  logic         m_ready
);

    pad_state_e   r_state_q,     w_state_d;
    logic [1:0]   r_widx_q,      w_widx_d;
    logic         r_pad_q,       w_pad_d;
    logic         r_in_stream_q, w_in_stream_d;
    logic         r_type_q,      w_type_d;
    logic [127:0] r_acc_q,       w_acc_d;
    logic [127:0] r_block_q,     w_block_d;
    logic [4:0]   r_bytes_q,     w_bytes_d;
    logic         r_mtype_q,     w_mtype_d;
    logic         r_last_q,      w_last_d;
    logic         r_empty_q,     w_empty_d;

    logic [2:0]   w_word_bytes;
    logic [4:0]   w_n;
    logic         w_cur_type;
    logic         w_is_empty;
    logic         w_complete;
    logic [127:0] w_fill;
    logic [127:0] w_padded;

    assign s_ready = !rst && (r_state_q == PAD_COLLECT);
    assign m_valid = !rst && (r_state_q != PAD_COLLECT);

    assign m_block = r_block_q;
    assign m_bytes = r_bytes_q;
    assign m_type  = r_mtype_q;
    assign m_last  = r_last_q;
    assign m_empty = r_empty_q;

    // Out-of-range byte counts are clamped so a bad s_bytes cannot leak lanes.
    always_comb begin
        w_word_bytes = 3'd4;
        if (s_last && (s_bytes < 3'd4)) begin
            w_word_bytes = s_bytes;
        end
        w_n        = {1'b0, r_widx_q, 2'b00} + {2'b00, w_word_bytes};
        w_cur_type = r_in_stream_q ? r_type_q : s_type;
        w_complete = s_last || (r_widx_q == 2'd3);
        w_is_empty = s_last && (w_word_bytes == 3'd0) && (r_widx_q == 2'd0)
                     && !r_in_stream_q && (s_type == SEL_AD);

        w_fill   = r_acc_q | ({96'd0, s_data} << {r_widx_q, 5'd0});
        w_padded = w_fill & lane_mask(w_n);
        if (w_n < 5'(RATE_BYTES)) begin
            w_padded = w_padded | ({120'd0, PAD_BYTE} << {w_n[3:0], 3'b000});
        end
        if (w_is_empty) begin
            w_padded = '0;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_widx_d      = r_widx_q;
        w_pad_d       = r_pad_q;
        w_in_stream_d = r_in_stream_q;
        w_type_d      = r_type_q;
        w_acc_d       = r_acc_q;
        w_block_d     = r_block_q;
        w_bytes_d     = r_bytes_q;
        w_mtype_d     = r_mtype_q;
        w_last_d      = r_last_q;
        w_empty_d     = r_empty_q;

        case (r_state_q)
            PAD_COLLECT: begin
                if (s_valid) begin
                    w_type_d = w_cur_type;
                    if (w_complete) begin
                        w_block_d     = w_padded;
                        w_bytes_d     = w_n;
                        w_mtype_d     = w_cur_type;
                        w_last_d      = s_last && (w_n < 5'(RATE_BYTES));
                        w_empty_d     = w_is_empty;
                        w_pad_d       = s_last && (w_n == 5'(RATE_BYTES));
                        w_in_stream_d = !s_last;
                        w_acc_d       = '0;
                        w_widx_d      = 2'd0;
                        w_state_d     = PAD_EMIT;
                    end else begin
                        w_acc_d[{r_widx_q, 5'd0} +: 32] = s_data;
                        w_widx_d      = r_widx_q + 2'd1;
                        w_in_stream_d = 1'b1;
                    end
                end
            end
            PAD_EMIT: begin
                if (m_ready) begin
                    if (r_pad_q) begin
                        // Exactly-full final block: padding lands in a block of its own.
                        w_block_d = {120'd0, PAD_BYTE};
                        w_bytes_d = 5'd0;
                        w_last_d  = 1'b1;
                        w_empty_d = 1'b0;
                        w_pad_d   = 1'b0;
                        w_state_d = PAD_EMIT_PAD;
                    end else begin
                        w_state_d = PAD_COLLECT;
                    end
                end
            end
            PAD_EMIT_PAD: begin
                if (m_ready) begin
                    w_state_d = PAD_COLLECT;
                end
            end
            default: begin
                w_state_d = PAD_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= PAD_COLLECT;
            r_widx_q      <= 2'd0;
            r_pad_q       <= 1'b0;
            r_in_stream_q <= 1'b0;
            r_type_q      <= SEL_AD;
            r_acc_q       <= '0;
            r_block_q     <= '0;
            r_bytes_q     <= 5'd0;
            r_mtype_q     <= SEL_AD;
            r_last_q      <= 1'b0;
            r_empty_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_widx_q      <= w_widx_d;
            r_pad_q       <= w_pad_d;
            r_in_stream_q <= w_in_stream_d;
            r_type_q      <= w_type_d;
            r_acc_q       <= w_acc_d;
            r_block_q     <= w_block_d;
            r_bytes_q     <= w_bytes_d;
            r_mtype_q     <= w_mtype_d;
            r_last_q      <= w_last_d;
            r_empty_q     <= w_empty_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_input_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_input_padder
// Description : Directed self-checking bench for ascon_input_padder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_input_padder;
    import ascon_aead128_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_type;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] m_block;
    logic [4:0]   m_bytes;
    logic         m_type;
    logic         m_last;
    logic         m_empty;
    logic         m_valid;
    logic         m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] cap_block;
    logic [4:0]   cap_bytes;
    logic         cap_type;
    logic         cap_last;
    logic         cap_empty;

    always #5 clk = ~clk;

    ascon_input_padder dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_bytes (s_bytes),
        .s_type  (s_type),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_block (m_block),
        .m_bytes (m_bytes),
        .m_type  (m_type),
        .m_last  (m_last),
        .m_empty (m_empty),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [31:0] d, input logic [2:0] b,
                        input logic t, input logic l);
        int n;
        s_data  = d;
        s_bytes = b;
        s_type  = t;
        s_last  = l;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (!s_ready) begin
            $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic get_beat(input string name);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (!m_valid) begin
            $display("FAIL %s_timeout: m_valid=%0b required 1", name, m_valid);
            n_fail++;
        end
        cap_block = m_block;
        cap_bytes = m_bytes;
        cap_type  = m_type;
        cap_last  = m_last;
        cap_empty = m_empty;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, m_valid} !== 2'b00) begin
            $display("FAIL reset_handshake: s_ready/m_valid=%b required 00", {s_ready, m_valid});
            n_fail++;
        end
        n_tests++;
        if (m_block !== 128'd0 || m_bytes !== 5'd0 || m_last !== 1'b0
            || m_empty !== 1'b0 || m_type !== SEL_AD) begin
            $display("FAIL reset_outputs: block=%h bytes=%0d last=%b empty=%b type=%b required all 0",
                     m_block, m_bytes, m_last, m_empty, m_type);
            n_fail++;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            $display("FAIL reset_release: s_ready=%b required 1", s_ready);
            n_fail++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ad5;
        send(32'h04030201, 3'd4, SEL_AD, 1'b0);
        send(32'h00000005, 3'd1, SEL_AD, 1'b1);
        n_tests++;
        if (m_valid !== 1'b1) begin
            $display("FAIL ad5_latency: m_valid=%b required 1", m_valid);
            n_fail++;
        end
        get_beat("ad5");
        n_tests++;
        if (cap_block !== 128'h0105_0403_0201 || cap_bytes !== 5'd5 || cap_last !== 1'b1
            || cap_empty !== 1'b0 || cap_type !== SEL_AD) begin
            $display("FAIL ad5_beat: block=%h bytes=%0d last=%b empty=%b type=%b required 0105_04030201/5/1/0/0",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
    endtask

    task automatic test_db16;
        send(32'h13121110, 3'd4, SEL_DB, 1'b0);
        send(32'h17161514, 3'd4, SEL_DB, 1'b0);
        send(32'h1B1A1918, 3'd4, SEL_DB, 1'b0);
        send(32'h1F1E1D1C, 3'd4, SEL_DB, 1'b1);
        get_beat("db16_full");
        n_tests++;
        if (cap_block !== 128'h1F1E1D1C_1B1A1918_17161514_13121110 || cap_bytes !== 5'd16
            || cap_last !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL db16_full: block=%h bytes=%0d last=%b type=%b required full/16/0/1",
                     cap_block, cap_bytes, cap_last, cap_type);
            n_fail++;
        end
        get_beat("db16_pad");
        n_tests++;
        if (cap_block !== 128'h01 || cap_bytes !== 5'd0 || cap_last !== 1'b1
            || cap_empty !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL db16_pad: block=%h bytes=%0d last=%b empty=%b type=%b required 01/0/1/0/1",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            $display("FAIL db16_done: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
            n_fail++;
        end
    endtask

    task automatic test_empty;
        send(32'hDEADBEEF, 3'd0, SEL_AD, 1'b1);
        get_beat("empty_ad");
        n_tests++;
        if (cap_block !== 128'd0 || cap_bytes !== 5'd0 || cap_last !== 1'b1
            || cap_empty !== 1'b1 || cap_type !== SEL_AD) begin
            $display("FAIL empty_ad: block=%h bytes=%0d last=%b empty=%b type=%b required 0/0/1/1/0",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
        send(32'hCAFEF00D, 3'd0, SEL_DB, 1'b1);
        get_beat("empty_db");
        n_tests++;
        if (cap_block !== 128'h01 || cap_bytes !== 5'd0 || cap_last !== 1'b1
            || cap_empty !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL empty_db: block=%h bytes=%0d last=%b empty=%b type=%b required 01/0/1/0/1",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
    endtask

    // Later words carry SEL_AD to show the stream type is taken from word 0.
    task automatic test_db20;
        send(32'h03020100, 3'd4, SEL_DB, 1'b0);
        send(32'h07060504, 3'd4, SEL_AD, 1'b0);
        send(32'h0B0A0908, 3'd4, SEL_AD, 1'b0);
        send(32'h0F0E0D0C, 3'd4, SEL_AD, 1'b0);
        get_beat("db20_b1");
        n_tests++;
        if (cap_block !== 128'h0F0E0D0C_0B0A0908_07060504_03020100 || cap_bytes !== 5'd16
            || cap_last !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL db20_b1: block=%h bytes=%0d last=%b type=%b required full/16/0/1",
                     cap_block, cap_bytes, cap_last, cap_type);
            n_fail++;
        end
        send(32'hA4A3A2A1, 3'd4, SEL_AD, 1'b1);
        get_beat("db20_b2");
        n_tests++;
        if (cap_block !== 128'h01_A4A3A2A1 || cap_bytes !== 5'd4 || cap_last !== 1'b1
            || cap_empty !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL db20_b2: block=%h bytes=%0d last=%b empty=%b type=%b required 01A4A3A2A1/4/1/0/1",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        send(32'hFF332211, 3'd3, SEL_AD, 1'b1);
        s_data  = 32'hEEEEEE77;
        s_bytes = 3'd1;
        s_type  = SEL_DB;
        s_last  = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_block !== 128'h01_332211
                || m_bytes !== 5'd3 || m_last !== 1'b1) begin
                $display("FAIL stall_cycle%0d: m_valid=%b s_ready=%b block=%h bytes=%0d last=%b required 1/0/01332211/3/1",
                         i, m_valid, s_ready, m_block, m_bytes, m_last);
                n_fail++;
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            $display("FAIL stall_release: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        get_beat("stall_next");
        n_tests++;
        if (cap_block !== 128'h0177 || cap_bytes !== 5'd1 || cap_last !== 1'b1 || cap_type !== SEL_DB) begin
            $display("FAIL stall_next: block=%h bytes=%0d last=%b type=%b required 0177/1/1/1",
                     cap_block, cap_bytes, cap_last, cap_type);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid;
        send(32'hAAAAAAAA, 3'd4, SEL_AD, 1'b0);
        send(32'hBBBBBBBB, 3'd4, SEL_AD, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (m_valid !== 1'b0) begin
                $display("FAIL rstmid_nobeat%0d: m_valid=%b required 0", i, m_valid);
                n_fail++;
            end
            @(posedge clk); #1;
        end
        send(32'h000000CC, 3'd1, SEL_DB, 1'b1);
        get_beat("rstmid");
        n_tests++;
        if (cap_block !== 128'h01CC || cap_bytes !== 5'd1 || cap_last !== 1'b1
            || cap_empty !== 1'b0 || cap_type !== SEL_DB) begin
            $display("FAIL rstmid_beat: block=%h bytes=%0d last=%b empty=%b type=%b required 01CC/1/1/0/1",
                     cap_block, cap_bytes, cap_last, cap_empty, cap_type);
            n_fail++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_data  = 32'd0;
        s_bytes = 3'd0;
        s_type  = SEL_AD;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_ad5();
        test_db16();
        test_empty();
        test_db20();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
